// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one single-port synchronous memory between fetch and data requesters
// Optional fetch anti-starvation guard: define ARB_STARVE_GUARD_EN.
module mem_port_arbiter #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_rvalid,
  output logic [DW-1:0] if_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [DW-1:0] d_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          stall_f,
  output logic          stall_m
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_IF = 2'd1,
    WAIT_D  = 2'd2
  } state_t;

  localparam logic [2:0] LAT = 3'(MEM_LAT);

  state_t        state_q, state_d;
  logic [2:0]    cnt_q, cnt_d;
  logic [DW-1:0] if_rdata_q, if_rdata_d;
  logic [DW-1:0] d_rdata_q, d_rdata_d;

  logic waiting;
  logic resp;
  logic slot;
  logic force_if;

  // A read is outstanding; its response cycle doubles as the next issue slot.
  // Reset suppresses both so nothing is granted or returned while rst is high.
  assign waiting = (state_q != IDLE);
  assign resp    = ~rst & waiting & (cnt_q == LAT);
  assign slot    = ~rst & (~waiting | (cnt_q == LAT));

`ifdef ARB_STARVE_GUARD_EN
  localparam int SW = $clog2(STARVE_MAX + 1);

  logic [SW-1:0] starve_q, starve_d;

  assign force_if = (starve_q >= SW'(STARVE_MAX));

  // Count data grants that made a waiting fetch lose; any fetch grant clears it.
  always_comb begin
    starve_d = starve_q;
    if (if_gnt) begin
      starve_d = '0;
    end else if (d_gnt && if_req && (starve_q != SW'(STARVE_MAX))) begin
      starve_d = starve_q + SW'(1);
    end
  end

  // Starvation counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end
`else
  assign force_if = 1'b0;
`endif

  // Arbitration: data wins (older instruction) unless the guard forces fetch.
  always_comb begin
    d_gnt     = slot & d_req & ~(force_if & if_req);
    if_gnt    = slot & if_req & (~d_req | force_if);
    mem_en    = d_gnt | if_gnt;
    mem_we    = d_gnt & d_we;
    mem_addr  = '0;
    mem_wdata = '0;
    if (d_gnt) begin
      mem_addr  = d_addr;
      mem_wdata = d_wdata;
    end else if (if_gnt) begin
      mem_addr  = if_addr;
    end
  end

  // Response decode and read-data hold registers.
  always_comb begin
    if_rvalid  = resp & (state_q == WAIT_IF);
    d_rvalid   = resp & (state_q == WAIT_D);
    if_rdata_d = if_rvalid ? mem_rdata : if_rdata_q;
    d_rdata_d  = d_rvalid  ? mem_rdata : d_rdata_q;
  end

  assign if_rdata = if_rdata_d;
  assign d_rdata  = d_rdata_d;

  // Stores finish in their grant cycle; reads park in WAIT_* while cnt counts up.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (d_gnt && !d_we) begin
      state_d = WAIT_D;
      cnt_d   = 3'd1;
    end else if (if_gnt) begin
      state_d = WAIT_IF;
      cnt_d   = 3'd1;
    end else if (slot) begin
      state_d = IDLE;
      cnt_d   = 3'd0;
    end else if (waiting) begin
      cnt_d   = cnt_q + 3'd1;
    end
  end

  // Pipeline freeze requests.
  assign stall_f = if_req & ~if_rvalid;
  assign stall_m = d_req & ~(d_gnt & d_we) & ~d_rvalid;

  // Sequencer state; reset drops any outstanding response.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= 3'd0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - randomized self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int LAT  = 3;
  localparam int SMAX = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_gnt;
  logic          if_rvalid;
  logic [DW-1:0] if_rdata;
  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_gnt;
  logic          d_rvalid;
  logic [DW-1:0] d_rdata;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          stall_f;
  logic          stall_m;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .AW(AW), .DW(DW), .MEM_LAT(LAT), .STARVE_MAX(SMAX)
  ) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .stall_f(stall_f), .stall_m(stall_m)
  );

  int total = 0;
  int bad   = 0;

  // reference model: transaction view (who is outstanding, which cycle it is due)
  int          cyc;
  int          pend;        // 0 none, 1 fetch, 2 data load
  int          due;
  logic [31:0] pend_data;
  logic [31:0] hold_if;
  logic [31:0] hold_d;
  int          starve;
  logic [31:0] ref_mem [64];

  // memory environment, driven only by the DUT's mem_* port
  logic [31:0] env_mem [64];
  logic [31:0] pipe [4];
  logic [31:0] next_rdata;

  // observations for directed checks
  logic        obs_ig, obs_dg;
  int          cnt_irv, cnt_drv, ig_cyc, dg_cyc;
  logic [31:0] last_ird, last_drd;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic int idx_of(input logic [31:0] a);
    return int'(a[7:2]);
  endfunction

  task automatic step();
    logic        resp, slot, frc, e_dg, e_ig, e_irv, e_drv;
    logic [31:0] e_addr, e_wd, e_ir, e_dr;
    @(negedge clk);
    resp = !rst && pend != 0 && cyc == due;
    slot = !rst && (pend == 0 || cyc == due);
`ifdef ARB_STARVE_GUARD_EN
    frc = (starve >= SMAX);
`else
    frc = 1'b0;
`endif
    e_dg   = slot && d_req && !(frc && if_req);
    e_ig   = slot && if_req && (!d_req || frc);
    e_irv  = resp && pend == 1;
    e_drv  = resp && pend == 2;
    e_addr = e_dg ? d_addr : (e_ig ? if_addr : 32'h0);
    e_wd   = e_dg ? d_wdata : 32'h0;
    e_ir   = e_irv ? pend_data : hold_if;
    e_dr   = e_drv ? pend_data : hold_d;

    check_eq("if_gnt", {31'b0, if_gnt}, {31'b0, e_ig});
    check_eq("d_gnt", {31'b0, d_gnt}, {31'b0, e_dg});
    check_eq("mem_en", {31'b0, mem_en}, {31'b0, e_ig | e_dg});
    check_eq("mem_we", {31'b0, mem_we}, {31'b0, e_dg & d_we});
    check_eq("mem_addr", mem_addr, e_addr);
    check_eq("mem_wdata", mem_wdata, e_wd);
    check_eq("if_rvalid", {31'b0, if_rvalid}, {31'b0, e_irv});
    check_eq("d_rvalid", {31'b0, d_rvalid}, {31'b0, e_drv});
    check_eq("if_rdata", if_rdata, e_ir);
    check_eq("d_rdata", d_rdata, e_dr);
    check_eq("stall_f", {31'b0, stall_f}, {31'b0, if_req & ~e_irv});
    check_eq("stall_m", {31'b0, stall_m}, {31'b0, d_req & ~(e_dg & d_we) & ~e_drv});

    obs_ig = if_gnt;
    obs_dg = d_gnt;
    if (if_gnt) ig_cyc = cyc;
    if (d_gnt) dg_cyc = cyc;
    if (if_rvalid) begin cnt_irv++; last_ird = if_rdata; end
    if (d_rvalid) begin cnt_drv++; last_drd = d_rdata; end

    for (int k = LAT - 1; k > 0; k--) pipe[k] = pipe[k-1];
    pipe[0] = (mem_en && !mem_we) ? env_mem[idx_of(mem_addr)] : 32'hDEAD_BEEF;
    if (mem_en && mem_we) env_mem[idx_of(mem_addr)] = mem_wdata;
    next_rdata = pipe[LAT-1];

    if (rst) begin
      pend = 0; hold_if = 0; hold_d = 0; starve = 0;
    end else begin
      if (e_irv) hold_if = pend_data;
      if (e_drv) hold_d = pend_data;
      if (e_dg && d_we) begin
        ref_mem[idx_of(d_addr)] = d_wdata;
        pend = 0;
      end else if (e_dg) begin
        pend = 2; due = cyc + LAT; pend_data = ref_mem[idx_of(d_addr)];
      end else if (e_ig) begin
        pend = 1; due = cyc + LAT; pend_data = ref_mem[idx_of(if_addr)];
      end else if (slot) begin
        pend = 0;
      end
      if (e_ig) starve = 0;
      else if (e_dg && if_req && starve < SMAX) starve++;
    end
    cyc++;
    @(posedge clk);
    #1;
    mem_rdata = next_rdata;
  endtask

  task automatic run_until_granted();
    for (int n = 0; n < 40 && (if_req || d_req); n++) begin
      step();
      if (obs_ig) if_req = 1'b0;
      if (obs_dg) d_req = 1'b0;
    end
    check_eq("grant_timeout", {31'b0, if_req | d_req}, 32'h0);
    if_req = 1'b0;
    d_req  = 1'b0;
  endtask

  task automatic settle();
    repeat (LAT + 1) step();
  endtask

  initial begin
    int base, k, ng_if, ng_d, exp_if;
    rst = 1'b1; if_req = 0; if_addr = 0; d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
    mem_rdata = 0;
    for (int i = 0; i < 64; i++) begin
      ref_mem[i] = $urandom;
      env_mem[i] = ref_mem[i];
    end
    ref_mem[0] = 32'h2008_0005;
    env_mem[0] = 32'h2008_0005;
    for (int i = 0; i < 4; i++) pipe[i] = 32'hDEAD_BEEF;
    cyc = 0; pend = 0; due = 0; pend_data = 0; hold_if = 0; hold_d = 0; starve = 0;
    cnt_irv = 0; cnt_drv = 0; ig_cyc = 0; dg_cyc = 0; last_ird = 0; last_drd = 0;
    obs_ig = 0; obs_dg = 0;
    repeat (2) @(posedge clk);
    #1;

    // reset state
    repeat (2) step();
    rst = 1'b0;

    // first fetch from 0x0
    if_req = 1; if_addr = 32'h0;
    run_until_granted();
    settle();
    check_eq("first_fetch_data", last_ird, 32'h2008_0005);

    // simultaneous load and fetch: load first, fetch in the load's response slot
    if_req = 1; if_addr = 32'h8; d_req = 1; d_we = 0; d_addr = 32'h40;
    run_until_granted();
    settle();
    check_eq("fetch_after_load", 32'(ig_cyc - dg_cyc), 32'(LAT));

    // store: no response, then read it back
    base = cnt_drv;
    d_req = 1; d_we = 1; d_addr = 32'h54; d_wdata = 32'h7;
    run_until_granted();
    settle();
    check_eq("store_no_rvalid", 32'(cnt_drv - base), 32'h0);
    d_req = 1; d_we = 0; d_addr = 32'h54;
    run_until_granted();
    settle();
    check_eq("store_readback", last_drd, 32'h7);

    // reset one cycle after a load grant discards the response
    d_req = 1; d_we = 0; d_addr = 32'h10;
    step();
    check_eq("load_gnt_before_rst", {31'b0, obs_dg}, 32'h1);
    d_req = 0; rst = 1;
    step();
    rst = 0;
    base = cnt_drv;
    settle();
    check_eq("rst_drops_rvalid", 32'(cnt_drv - base), 32'h0);

    // back-to-back fetches at 0x0, 0x4, 0x8
    base = cnt_irv; k = 0;
    if_req = 1; if_addr = 32'h0;
    for (int n = 0; n < 40 && k < 3; n++) begin
      step();
      if (obs_ig) begin
        k++;
        if_addr = 32'(k * 4);
        if (k == 3) if_req = 0;
      end
    end
    if_req = 0;
    settle();
    check_eq("b2b_fetch_count", 32'(cnt_irv - base), 32'h3);

    // both requesters held: fetch only gets in through the starvation guard
    ng_if = 0; ng_d = 0;
    if_req = 1; if_addr = 32'h20; d_req = 1; d_we = 0; d_addr = 32'h30;
    repeat (10 * LAT) begin
      step();
      if (obs_ig) ng_if++;
      if (obs_dg) ng_d++;
    end
    if_req = 0; d_req = 0;
    settle();
`ifdef ARB_STARVE_GUARD_EN
    exp_if = 10 / (SMAX + 1);
`else
    exp_if = 0;
`endif
    check_eq("starve_fetch_grants", 32'(ng_if), 32'(exp_if));
    check_eq("starve_data_grants", 32'(ng_d), 32'(10 - exp_if));

    // random traffic with occasional resets
    for (int n = 0; n < 1500; n++) begin
      step();
      rst = ($urandom_range(0, 199) == 0);
      if (!if_req || obs_ig) begin
        if_req  = ($urandom_range(0, 2) != 0);
        if_addr = {24'b0, 6'($urandom_range(0, 63)), 2'b00};
      end else if ($urandom_range(0, 15) == 0) begin
        if_req = 0;
      end
      if (!d_req || obs_dg) begin
        d_req   = ($urandom_range(0, 2) == 0);
        d_we    = $urandom_range(0, 1) == 1;
        d_addr  = {24'b0, 6'($urandom_range(0, 63)), 2'b00};
        d_wdata = $urandom;
      end else if ($urandom_range(0, 15) == 0) begin
        d_req = 0;
      end
    end
    rst = 0; if_req = 0; d_req = 0;
    settle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port synchronous memory between two requesters: the fetch stage (instruction reads) and the memory stage (data loads and stores).
- Sequences each access and waits out the fixed memory latency before returning read data.
- Produces the stall signals the pipeline uses to freeze the fetch and memory stages while an access is pending or lost arbitration.
- Sits between the pipelined datapath and the unified memory; replaces the separate instruction ROM and data RAM ports.

Parameters:
- AW, 32, address width.
- DW, 32, data width.
- MEM_LAT, 1, cycles from the mem_en issue cycle to valid mem_rdata. Legal range 1..4.
- STARVE_MAX, 4, consecutive data grants allowed before fetch is forced. Used only with the optional feature.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- if_req  in  1  fetch read request; held until if_gnt.
- if_addr  in  AW  fetch address; stable while if_req is high and not yet granted.
- if_gnt  out  1  fetch request accepted this cycle.
- if_rvalid  out  1  one-cycle pulse; if_rdata is valid.
- if_rdata  out  DW  fetch read data.
- d_req  in  1  data request; held until d_gnt.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  AW  data address.
- d_wdata  in  DW  store data.
- d_gnt  out  1  data request accepted this cycle.
- d_rvalid  out  1  one-cycle pulse; d_rdata is valid (loads only).
- d_rdata  out  DW  load data.
- mem_en  out  1  memory access issued this cycle.
- mem_we  out  1  memory write enable; qualified by mem_en.
- mem_addr  out  AW  memory address.
- mem_wdata  out  DW  memory write data.
- mem_rdata  in  DW  memory read data; valid MEM_LAT cycles after issue.
- stall_f  out  1  freeze the PC and the fetch/decode register.
- stall_m  out  1  freeze the memory stage and all earlier stages.

Behaviour:
- FSM states: IDLE, WAIT_IF, WAIT_D. A 3-bit latency counter cnt tracks the outstanding read.
- Issue slot: asserted in IDLE, or in WAIT_* when cnt == MEM_LAT (the response cycle). Arbitration happens only in an issue slot.
- Arbitration priority: data beats fetch, because the memory-stage instruction is older.
- Grant outputs are combinational in the issue slot:
  - d_gnt = slot & d_req.
  - if_gnt = slot & if_req & ~d_req.
  - mem_en = d_gnt | if_gnt; mem_we = d_gnt & d_we.
  - mem_addr and mem_wdata come from the granted requester; they are 0 when nothing is granted.
- Store grant: the write completes in the grant cycle. No rvalid is produced. Next state is IDLE unless a read is also pending at the slot.
- Load or fetch grant:
  - Next state is WAIT_D or WAIT_IF; cnt loads 1.
  - cnt increments each cycle while in WAIT_*.
  - When cnt == MEM_LAT: pulse the matching rvalid, drive rdata = mem_rdata, and treat the cycle as an issue slot (back-to-back accesses allowed).
  - With no new grant in that cycle, next state is IDLE.
- rdata outputs hold their last value when rvalid is low. Only one access is outstanding at a time.
- Stalls:
  - stall_f = if_req & ~if_rvalid.
  - stall_m = d_req & ~(d_gnt & d_we) & ~d_rvalid.
- Simultaneous if_req and d_req: the data request is granted. Fetch waits at least until the data response slot.
- Reset values: state IDLE, cnt 0, if_rdata and d_rdata 0, all rvalid/gnt/mem_en deasserted.
- Reset during WAIT_*: the outstanding response is discarded and no rvalid is produced. The first grant after reset is in the cycle after rst deasserts.
- A requester dropping req before its grant is legal; no access is issued for it.

Optional Feature:
- Macro ARB_STARVE_GUARD_EN.
- When defined: a counter tracks consecutive data grants issued while if_req was high.
  - When it reaches STARVE_MAX, the next slot with both requests pending grants fetch, and the counter clears.
  - The counter also clears on any fetch grant and on rst.
- When undefined: strict data priority; fetch can starve indefinitely.

Test Plan:
- Reset then if_req=1, if_addr=0x0, MEM_LAT=1, mem_rdata=0x20080005 → if_gnt in cycle 1; if_rvalid=1, if_rdata=0x20080005 in cycle 2; stall_f high in cycle 1, low in cycle 2.
- if_req and d_req (load, d_addr=0x40) asserted together → d_gnt first, mem_addr=0x40; if_gnt in d_rvalid cycle; fetch data returned MEM_LAT later.
- Store d_we=1, d_addr=0x54, d_wdata=0x7 → mem_en=mem_we=1, mem_wdata=0x7 in grant cycle; d_rvalid never asserted; stall_m low in grant cycle.
- MEM_LAT=3, load issued → d_rvalid exactly 3 cycles after d_gnt, stall_m high for those 3 cycles. rst pulsed 1 cycle after grant → no d_rvalid, state IDLE.
- With ARB_STARVE_GUARD_EN, STARVE_MAX=4: d_req and if_req held high continuously → 4 data grants then 1 fetch grant, repeating. Without the macro → no fetch grant while d_req is high.
- Back-to-back fetches at 0x0, 0x4, 0x8 with MEM_LAT=1 → one if_rvalid every cycle after the first, with if_gnt coincident with each prior if_rvalid.
